rv_instr_encoder: RTL and testbench
===================================

// Module: rv_instr_encoder
// PURPOSE
//  Inverse of the main decoder: packs decoded fields (opCode, funct3/funct7, rs1/rs2/rd, imm) into
//  RV32I instruction words. Streams the words, with sequential word addresses, to instruction memory.
//  Used by the boot/program loader and by self-checking benches (encode -> decode round trip).
//  Valid/ready input; 2-entry output FIFO; address counter on the output side.
// PARAMETERS
//  ADDR_W   32      width of out_addr / base_addr (byte address)
//  ERRCNT_W 8       width of err_cnt (saturating)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       encoder can accept (FIFO not full)
//  fmt        in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  opCode     in   7       placed verbatim in [6:0]
//  funct3     in   3       [14:12] (ignored for U/J)
//  funct7     in   7       [31:25] for R; for I shift ops (see BEHAVIOUR)
//  rs1,rs2,rd in   5 each  register fields, used per format
//  imm        in   32      signed byte offset/value (U: imm[31:12] used)
//  out_valid  out  1       word available
//  out_ready  in   1       memory accepts word
//  out_instr  out  32      encoded word
//  out_addr   out  ADDR_W  byte address of out_instr
//  load_base  in   1       pulse: next address := base_addr
//  base_addr  in   ADDR_W  new base
//  err_sticky out  1       range error seen since clear_err
//  err_cnt    out  ERRCNT_W dropped-entry count
//  clear_err  in   1       clears err_sticky and err_cnt
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_instr=0, out_addr=0, FIFO empty, err_sticky=0, err_cnt=0.
//  Accept on in_valid&&in_ready; encoding is combinational into FIFO write; latency 1
//   (accept cycle N -> out_valid at N+1 when FIFO was empty). Pop on out_valid&&out_ready.
//  in_ready = (count<2), registered from count; push+pop same cycle when count==1 keeps count 1.
//  Output data is stable while out_valid && !out_ready; no bubbles at full throughput.
//  Packing (standard RV32I): R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op};
//   I with op=0010011 and f3 in {001,101}: {f7,imm[4:0],rs1,f3,rd,op};
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//   U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  fmt 6/7: entry accepted and dropped; with range-check macro, counted as an error.
//  Address: addr_q increments by 4 on each pop, wraps mod 2^ADDR_W; out_addr=addr_q.
//   load_base same cycle as pop: popped word uses old addr_q, next addr_q=base_addr.
//  Reset mid-stream: FIFO contents discarded, addr_q=0.
//  clear_err takes priority over a same-cycle error increment; err_cnt saturates at all-ones.
// CONFIGURATION
//  INSTR_ENC_RANGE_CHECK_EN defined:
//   - Entry dropped, err_sticky set and err_cnt incremented (FIFO untouched) when imm does not fit:
//     I/S outside [-2048,2047]; B outside [-4096,4094] or odd; J outside [-2^20,2^20-2] or odd;
//     U imm[11:0]!=0; shift imm outside 0..31.
//  Not defined: imm silently truncated/packed; fmt 6/7 dropped silently; err_* tied to 0.
// STRUCTURE
//  Package rv_defs_pkg: fmt codes, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
//   LUI, AUIPC), field bit positions. Shared with the main decoder.
//  Sub-module rv_instr_pack: purely combinational fields->word packer plus range-check flag.
//  The top level holds the FIFO, address counter and error counters.
// TESTING
//  R ADD x3,x1,x2 (f7=0,f3=0,op=0110011) -> 0x002081B3 at out_addr 0 after 1 cycle.
//  I ADDI x1,x0,5 -> 0x00500093; SRAI x1,x1,3 (f7=0100000,f3=101) -> 0x4030D093.
//  SW x2,8(x1) -> 0x0020A423; BEQ x1,x2,+8 -> 0x00208463; LUI x5,0x12345000 -> 0x123452B7;
//   JAL x1,+16 -> 0x010000EF; addresses increment 0,4,8,...
//  Backpressure: out_ready=0, push 3 -> in_ready drops after 2; release -> 3 words in order, none lost.
//  load_base=0x100 with pop in same cycle -> popped word keeps old addr, next word at 0x100;
//   base 0xFFFFFFFC -> wraps to 0.
//  (RANGE_CHECK_EN) BEQ imm=5 or ADDI imm=4096 -> no output, err_sticky=1, err_cnt=1;
//   clear_err -> 0. Async rst_n mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/rv_defs_pkg.sv
// rv_defs_pkg: RV32I format codes, opcodes and field positions shared by the encoder and the main decoder.
package rv_defs_pkg;
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;
   function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
      return op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101);
   endfunction
   function automatic logic fits_signed(input logic [31:0] v, input int n);
      int s;
      s = $signed(v);
      return s >= -(1 <<< (n - 1)) && s < (1 <<< (n - 1));
   endfunction
endpackage

// File: rtl/rv_instr_pack.sv
// rv_instr_pack: combinational field bundle -> RV32I word packer with drop flag.
// Range checking of imm is enabled by INSTR_ENC_RANGE_CHECK_EN.
module rv_instr_pack
   import rv_defs_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        drop
);
   logic shift, illegal;
   assign shift = is_shift(opcode, funct3);
   always_comb begin
      illegal = 1'b0;
      instr = '0;
      case (fmt)
         FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: instr = shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                              : {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U: instr = {imm[31:12], rd, opcode};
         FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: illegal = 1'b1;
      endcase
   end
`ifdef INSTR_ENC_RANGE_CHECK_EN
   logic range_err;
   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_I: range_err = shift ? (imm > 32'd31) : !fits_signed(imm, 12);
         FMT_S: range_err = !fits_signed(imm, 12);
         FMT_B: range_err = !fits_signed(imm, 13) || imm[0];
         FMT_U: range_err = imm[11:0] != 12'd0;
         FMT_J: range_err = !fits_signed(imm, 21) || imm[0];
         default: range_err = 1'b0;
      endcase
   end
   assign drop = illegal | range_err;
`else
   assign drop = illegal;
`endif
endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs field bundles into RV32I words and streams them with byte addresses
// through a 2-entry FIFO; INSTR_ENC_RANGE_CHECK_EN enables imm range errors and counters.
module rv_instr_encoder
   import rv_defs_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          fmt,
   input  logic [6:0]          opCode,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   input  logic [4:0]          rd,
   input  logic [31:0]         imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   input  logic                load_base,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_cnt,
   input  logic                clear_err
);
   logic [31:0] mem [2];
   logic [1:0] count;
   logic wr_ptr, rd_ptr;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0] word;
   logic drop, accept, push, pop;
   rv_instr_pack u_pack (
      .fmt(fmt), .opcode(opCode), .funct3(funct3), .funct7(funct7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .instr(word), .drop(drop)
   );
   assign in_ready  = count != 2'd2;
   assign accept    = in_valid && in_ready;
   assign push      = accept && !drop;
   assign out_valid = count != 2'd0;
   assign pop       = out_valid && out_ready;
   assign out_instr = mem[rd_ptr];
   assign out_addr  = addr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         addr_q <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= word;
            wr_ptr <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         count  <= count + 2'(push) - 2'(pop);
         addr_q <= load_base ? base_addr : pop ? addr_q + ADDR_W'(4) : addr_q;
      end
   end
`ifdef INSTR_ENC_RANGE_CHECK_EN
   // every rejected bundle (bad fmt or imm out of range) is an error
   logic err_ev;
   assign err_ev = accept && drop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else if (clear_err) begin
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else if (err_ev) begin
         err_sticky <= 1'b1;
         err_cnt    <= (err_cnt == '1) ? err_cnt : err_cnt + ERRCNT_W'(1);
      end
   end
`else
   logic unused_clear;
   assign unused_clear = clear_err;
   assign err_sticky = 1'b0;
   assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: randomized scoreboard bench for rv_instr_encoder against an arithmetic RV32I model.
module tb_rv_instr_encoder;
   typedef struct packed {
      logic [2:0]  f;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  d;
      logic [31:0] im;
   } fld_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [2:0] fmt = '0, funct3 = '0;
   logic [6:0] opCode = '0, funct7 = '0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic [31:0] imm = '0, out_instr, out_addr, base_addr = '0;
   logic load_base = 1'b0, clear_err = 1'b0, err_sticky;
   logic [7:0] err_cnt;

   int cmp = 0, fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_addr = '0;
   logic exp_sticky = 1'b0;
   logic [7:0] exp_cnt = '0;
   bit done = 0;

   rv_instr_encoder #(.ADDR_W(32), .ERRCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opCode(opCode), .funct3(funct3), .funct7(funct7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .load_base(load_base), .base_addr(base_addr),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic bit model_ok(input fld_t x);
      int s;
      s = $signed(x.im);
      if (x.f > 3'd5) return 0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
      case (x.f)
         3'd1: if (x.op == 7'h13 && (x.f3 == 3'd1 || x.f3 == 3'd5)) return s >= 0 && s <= 31;
               else return s >= -2048 && s <= 2047;
         3'd2: return s >= -2048 && s <= 2047;
         3'd3: return s >= -4096 && s <= 4094 && (s % 2) == 0;
         3'd4: return (x.im % 4096) == 0;
         3'd5: return s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2) == 0;
         default: return 1;
      endcase
`else
      return 1;
`endif
   endfunction

   function automatic logic [31:0] model_word(input fld_t x);
      logic [31:0] i, op, d, f3, r1, r2, f7;
      i = x.im; op = 32'(x.op); d = 32'(x.d) << 7; f3 = 32'(x.f3) << 12;
      r1 = 32'(x.r1) << 15; r2 = 32'(x.r2) << 20; f7 = 32'(x.f7) << 25;
      case (x.f)
         3'd0: return f7 | r2 | r1 | f3 | d | op;
         3'd1: if (x.op == 7'h13 && (x.f3 == 3'd1 || x.f3 == 3'd5))
                  return f7 | ((i % 32) << 20) | r1 | f3 | d | op;
               else return ((i % 4096) << 20) | r1 | f3 | d | op;
         3'd2: return (((i >> 5) % 128) << 25) | r2 | r1 | f3 | ((i % 32) << 7) | op;
         3'd3: return (((i >> 12) % 2) << 31) | (((i >> 5) % 64) << 25) | r2 | r1 | f3
                      | (((i >> 1) % 16) << 8) | (((i >> 11) % 2) << 7) | op;
         3'd4: return ((i / 4096) * 4096) | d | op;
         default: return (((i >> 20) % 2) << 31) | (((i >> 1) % 1024) << 21)
                         | (((i >> 11) % 2) << 20) | (((i >> 12) % 256) << 12) | d | op;
      endcase
   endfunction

   function automatic fld_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] d, input logic [31:0] im);
      fld_t x;
      x.f = f; x.op = op; x.f3 = f3; x.f7 = f7; x.r1 = r1; x.r2 = r2; x.d = d; x.im = im;
      return x;
   endfunction

   function automatic fld_t rand_fld();
      fld_t x;
      int k;
      x.f  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      x.op = 7'($urandom); x.f3 = 3'($urandom); x.f7 = 7'($urandom);
      x.r1 = 5'($urandom); x.r2 = 5'($urandom); x.d = 5'($urandom);
      if (x.f == 3'd1 && $urandom_range(0, 2) == 0) begin
         x.op = 7'h13;
         x.f3 = $urandom_range(0, 1) ? 3'd1 : 3'd5;
      end
      k = $urandom_range(0, 3);
      x.im = (k == 0) ? 32'($urandom) :
             (k == 1) ? 32'($urandom_range(0, 40)) - 32'd8 :
             (k == 2) ? 32'($urandom_range(0, 8191)) - 32'd4096 :
                        32'($urandom) & 32'hFFFF_F000;
      return x;
   endfunction

   // issue one bundle; the expected word (or expected error) is recorded at the accepting edge
   task automatic send(input fld_t x, input bit dir, input logic [31:0] w);
      fmt = x.f; opCode = x.op; funct3 = x.f3; funct7 = x.f7;
      rs1 = x.r1; rs2 = x.r2; rd = x.d; imm = x.im; in_valid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (in_ready) break;
         if (t == 300) begin
            cmp++; fail++;
            $display("FAIL accept_timeout: in_ready stuck low at %0t", $time);
            in_valid = 1'b0;
            return;
         end
      end
      if (model_ok(x)) exp_q.push_back(dir ? w : model_word(x));
      else begin
`ifdef INSTR_ENC_RANGE_CHECK_EN
         exp_sticky = 1'b1;
         if (exp_cnt != 8'hFF) exp_cnt++;
`endif
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
         if (t == 500) begin
            cmp++; fail++;
            $display("FAIL drain_timeout: %0d words outstanding", exp_q.size());
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_err(input string n);
      chk({n, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
      chk({n, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
   endtask

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  cmp++; fail++;
                  $display("FAIL unexpected_word: got 0x%08h with nothing expected", out_instr);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", out_instr, e);
                  chk("addr", out_addr, m_addr);
               end
            end
            if (load_base) m_addr = base_addr;
            else if (out_valid && out_ready) m_addr += 32'd4;
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk_err("rst_err");
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0), 1, 32'h002081B3);
      send(mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5), 1, 32'h00500093);
      send(mk(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd0, 5'd1, 32'd3), 1, 32'h4030D093);
      send(mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8), 1, 32'h0020A423);
      send(mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8), 1, 32'h00208463);
      send(mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000), 1, 32'h123452B7);
      send(mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd16), 1, 32'h010000EF);
      send(mk(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0), 0, 32'd0);
      drain();
      chk_err("fmt6");
      // backpressure: third push must stall until the sink drains
      out_ready = 1'b0;
      fork
         begin
            send(mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd4, 5'd5, 5'd6, 32'd0), 1, 32'h00520333);
            send(mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'd7), 1, 32'h00700113);
            send(mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hABCDE000), 1, 32'hABCDE0B7);
         end
         begin
            repeat (5) @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      // load_base coinciding with a pop
      out_ready = 1'b0;
      send(mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'd1), 1, 32'h00100193);
      send(mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 32'd2), 1, 32'h00200213);
      out_ready = 1'b1; load_base = 1'b1; base_addr = 32'h100;
      @(posedge clk); #1;
      load_base = 1'b0;
      drain();
      chk("base_addr_now", out_addr, 32'h104);
      out_ready = 1'b0; load_base = 1'b1; base_addr = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      load_base = 1'b0;
      send(mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0), 1, 32'h001080B3);
      send(mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd2, 5'd2, 5'd2, 32'd0), 1, 32'h00210133);
      drain();
      chk("wrap_addr_now", out_addr, 32'h4);
`ifdef INSTR_ENC_RANGE_CHECK_EN
      send(mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd5), 0, 32'd0);
      drain();
      chk("beq_odd_sticky", 32'(err_sticky), 32'd1);
      chk("beq_odd_cnt", 32'(err_cnt), 32'd1);
      clear_err = 1'b1; exp_sticky = 1'b0; exp_cnt = '0;
      @(posedge clk); #1;
      clear_err = 1'b0;
      chk_err("clear1");
      send(mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd4096), 0, 32'd0);
      drain();
      chk("addi_big_cnt", 32'(err_cnt), 32'd1);
`endif
      clear_err = 1'b1; exp_sticky = 1'b0; exp_cnt = '0;
      @(posedge clk); #1;
      clear_err = 1'b0;
      chk_err("clear2");
      fork
         begin
            for (int n = 0; n < 300; n++) send(rand_fld(), 0, 32'd0);
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = $urandom_range(0, 3) != 0;
            end
         end
      join
      drain();
      chk_err("random_err");
      // asynchronous reset with a word pending
      out_ready = 1'b0;
      send(mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0), 1, 32'h002081B3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_addr", out_addr, 32'd0);
      exp_q.delete(); m_addr = '0; exp_sticky = 1'b0; exp_cnt = '0;
      #1 rst_n = 1'b1;
      send(mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd16), 1, 32'h010000EF);
      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
      $finish;
   end
endmodule
